pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline sequencing controller for the RISCV-Lite five-stage core (IF, ID, EX, MEM, WB). It tracks register producers in the EX, MEM and WB stages with its own shadow pipeline and detects data hazards against the instruction in ID. It drives PC and IF/ID enables, IF/ID and ID/EX flushes, and EX operand forwarding selects. It also honours an external memory-wait freeze and counts stall cycles.

## Interface
- No parameters.
- clk_i  in  1  core clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- instr_id_i  in  32  instruction currently held in IF/ID.
- instr_valid_i  in  1  IF/ID holds a real instruction; 0 means bubble.
- branch_taken_ex_i  in  1  taken branch, jal or jalr resolved in EX this cycle.
- ext_stall_i  in  1  memory wait; freeze the whole pipeline.
- pc_en_o  out  1  PC register load enable.
- ifid_en_o  out  1  IF/ID register load enable.
- ifid_flush_o  out  1  load a bubble into IF/ID.
- idex_flush_o  out  1  load a bubble into ID/EX.
- fwd_a_o  out  2  EX rs1 source: 00 register file, 01 EX/MEM, 10 MEM/WB.
- fwd_b_o  out  2  EX rs2 source, same encoding as fwd_a_o.
- stall_cnt_o  out  16  saturating count of stall cycles (hazard stalls plus freeze cycles).

## Operation
- Decode of instr_id_i:
  - op = instr[6:2], rd = instr[11:7], rs1 = instr[19:15], rs2 = instr[24:20].
  - Writes rd: lui 01101, auipc 00101, op-imm 00100, op 01100, lw 00000, jal 11011, jalr 11001. A destination of rd = 0 never counts as a write.
  - Uses rs1: op-imm, op, lw, sw 01000, jalr, branch 11000.
  - Uses rs2: op, sw, branch.
  - is_load: op 00000.
- Shadow entries: EX, MEM, WB each hold {valid, wr, rd, is_load, rs1, rs2}.
- Per-cycle shadow update when not frozen:
  - WB takes MEM; MEM takes EX.
  - EX takes the decoded ID entry, or a bubble when stalling, flushing, or instr_valid_i = 0.
- Hazard: a valid shadow entry with wr = 1 whose rd equals a used source of ID.
- FSM states:
  - RUN: default state.
  - HAZ: entered when a hazard stall is asserted; returns to RUN on the first cycle with no hazard.
  - HOLD: entered from any state when ext_stall_i = 1; left the cycle after ext_stall_i drops, to RUN (HAZ is re-evaluated combinationally).
- Outputs while stalling: pc_en_o = 0, ifid_en_o = 0, idex_flush_o = 1.
- Outputs on flush (branch_taken_ex_i = 1, not frozen): ifid_flush_o = 1, idex_flush_o = 1, pc_en_o = 1. Flush overrides any hazard stall in the same cycle.
- Outputs in HOLD: pc_en_o = 0, ifid_en_o = 0, both flushes 0, shadow frozen. branch_taken_ex_i is ignored because EX is held and re-presents the branch after release.
- stall_cnt_o increments on every HAZ or HOLD cycle and saturates at 16'hFFFF.

## Timing
- Reset (asynchronous): shadow all bubbles, state RUN, counter 0. Outputs: pc_en_o = 1, ifid_en_o = 1, ifid_flush_o = 0, idex_flush_o = 0, fwd_a_o = 00, fwd_b_o = 00, stall_cnt_o = 0.
- Control outputs are combinational from instr_id_i, inputs and registered shadow; there is no added latency.
- Forwarding selects use the EX shadow sources against the MEM and WB shadows. EX/MEM (01) has priority over MEM/WB (10).
- Reset asserted mid-stall or mid-freeze: immediate return to the reset values. No pending stall survives reset.

## Configuration
- FORWARDING_EN defined:
  - Stall only on load-use, i.e. the EX entry has is_load = 1 and a matching rd. This gives exactly 1 stall cycle.
  - Forwarding is active.
- FORWARDING_EN undefined:
  - Stall while the EX or MEM entry matches, giving up to 2 stall cycles.
  - The register file is write-through, so the WB entry never stalls.
  - fwd_a_o and fwd_b_o are tied to 00.

## Structure
- my_pkg holds:
  - Opcode constants OP_LUI, OP_AUIPC, OP_IMM, OP_REG, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR.
  - typedef enum ctrl_state_t {RUN, HAZ, HOLD}.
  - typedef enum fwd_sel_t {FWD_RF, FWD_EXMEM, FWD_MEMWB}.
  - typedef struct shadow_t.
- Sub-module pipe_decode: purely combinational instruction to shadow_t decode.

## Test plan
- FORWARDING_EN, "lw x5,0(x1)" in EX, "add x6,x5,x2" in ID -> 1 cycle with pc_en_o = 0 and idex_flush_o = 1. Next cycle, with add in EX, fwd_a_o = 10.
- FORWARDING_EN, "addi x5,x0,1" then "add x6,x5,x5" -> no stall; in EX, fwd_a_o = 01 and fwd_b_o = 01.
- Without FORWARDING_EN, same addi/add pair -> 2 stall cycles; stall_cnt_o goes from 0 to 2.
- Load-use hazard in ID with branch_taken_ex_i = 1 in the same cycle -> ifid_flush_o = 1, idex_flush_o = 1, pc_en_o = 1, no stall.
- "addi x0,x0,5" followed by an instruction using x0 -> no stall, fwd 00.
- ext_stall_i high for 3 cycles during a HAZ stall -> outputs frozen, counter +3 plus the remaining hazard cycle. Pulse rst_i mid-freeze -> all outputs return to reset values on the same edge.

Source files
------------

// File: rtl/my_pkg.sv
// Shared opcode constants, FSM/forwarding enums and the shadow-pipeline entry
// type used by pipe_ctrl and pipe_decode.
package my_pkg;

    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_IMM    = 5'b00100;
    localparam logic [4:0] OP_REG    = 5'b01100;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;

    typedef enum logic [1:0] {
        RUN  = 2'b00,
        HAZ  = 2'b01,
        HOLD = 2'b10
    } ctrl_state_t;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_t;

    // rs1/rs2 are zero when the instruction does not read that source, so an
    // unused field can never match a producer.
    typedef struct packed {
        logic       valid;
        logic       wr;
        logic [4:0] rd;
        logic       is_load;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } shadow_t;

    localparam shadow_t BUBBLE = '0;

    // True when entry e produces register rs; x0 is never a dependency.
    function automatic logic src_hit(input shadow_t e, input logic [4:0] rs);
        return e.valid && e.wr && (rs != 5'd0) && (e.rd == rs);
    endfunction

endpackage

// File: rtl/pipe_decode.sv
// Combinational decode of the IF/ID instruction into a shadow_t entry
// (destination, load flag and the source registers it actually reads).
module pipe_decode
    import my_pkg::*;
(
    input  logic [31:0] instr,
    input  logic        valid,
    output shadow_t     entry
);

    logic [4:0] op_s;
    logic       wr_s;
    logic       use1_s;
    logic       use2_s;
    logic       unused_s;

    assign op_s     = instr[6:2];
    assign unused_s = ^{instr[31:25], instr[14:12], instr[1:0]};

    // Opcode class: which opcodes write rd and which read rs1/rs2.
    always_comb begin
        wr_s   = 1'b0;
        use1_s = 1'b0;
        use2_s = 1'b0;
        case (op_s)
            OP_LUI, OP_AUIPC, OP_JAL: begin
                wr_s = 1'b1;
            end
            OP_IMM, OP_LOAD, OP_JALR: begin
                wr_s   = 1'b1;
                use1_s = 1'b1;
            end
            OP_REG: begin
                wr_s   = 1'b1;
                use1_s = 1'b1;
                use2_s = 1'b1;
            end
            OP_STORE, OP_BRANCH: begin
                use1_s = 1'b1;
                use2_s = 1'b1;
            end
            default: begin
                wr_s   = 1'b0;
                use1_s = 1'b0;
                use2_s = 1'b0;
            end
        endcase
    end

    // Assemble the entry; a bubble in IF/ID decodes to an all-zero entry.
    always_comb begin
        entry = BUBBLE;
        if (valid) begin
            entry.valid   = 1'b1;
            entry.wr      = wr_s && (instr[11:7] != 5'd0);
            entry.rd      = instr[11:7];
            entry.is_load = (op_s == OP_LOAD);
            entry.rs1     = use1_s ? instr[19:15] : 5'd0;
            entry.rs2     = use2_s ? instr[24:20] : 5'd0;
        end else begin
            entry = BUBBLE;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline sequencer: hazard stall, branch flush, memory-wait freeze,
// EX forwarding selects and stall counter. Build option: FORWARDING_EN.
module pipe_ctrl
    import my_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] instr_id_i,
    input  logic        instr_valid_i,
    input  logic        branch_taken_ex_i,
    input  logic        ext_stall_i,
    output logic        pc_en_o,
    output logic        ifid_en_o,
    output logic        ifid_flush_o,
    output logic        idex_flush_o,
    output logic [1:0]  fwd_a_o,
    output logic [1:0]  fwd_b_o,
    output logic [15:0] stall_cnt_o
);

    shadow_t     id_s;
    shadow_t     ex_r;
    shadow_t     mem_r;
    shadow_t     wb_r;
    ctrl_state_t state_r;
    ctrl_state_t state_nxt_s;
    fwd_sel_t    fwd_a_s;
    fwd_sel_t    fwd_b_s;
    logic        hazard_s;
    logic        freeze_s;
    logic        flush_s;
    logic        stall_s;
    logic [15:0] cnt_r;
    logic        unused_s;

    pipe_decode u_decode (
        .instr (instr_id_i),
        .valid (instr_valid_i),
        .entry (id_s)
    );

    assign unused_s = ^{wb_r, mem_r, ex_r};

`ifdef FORWARDING_EN
    // Only a load still in EX is too late to forward from.
    always_comb begin
        hazard_s = 1'b0;
        if (ex_r.is_load && (src_hit(ex_r, id_s.rs1) || src_hit(ex_r, id_s.rs2))) begin
            hazard_s = 1'b1;
        end else begin
            hazard_s = 1'b0;
        end
    end

    // EX operand sources; the younger MEM producer wins over WB.
    always_comb begin
        fwd_a_s = FWD_RF;
        fwd_b_s = FWD_RF;
        if (src_hit(mem_r, ex_r.rs1)) begin
            fwd_a_s = FWD_EXMEM;
        end else if (src_hit(wb_r, ex_r.rs1)) begin
            fwd_a_s = FWD_MEMWB;
        end else begin
            fwd_a_s = FWD_RF;
        end
        if (src_hit(mem_r, ex_r.rs2)) begin
            fwd_b_s = FWD_EXMEM;
        end else if (src_hit(wb_r, ex_r.rs2)) begin
            fwd_b_s = FWD_MEMWB;
        end else begin
            fwd_b_s = FWD_RF;
        end
    end
`else
    // Without bypass, wait until the producer reaches the write-through WB.
    always_comb begin
        hazard_s = 1'b0;
        if (src_hit(ex_r, id_s.rs1) || src_hit(ex_r, id_s.rs2) ||
            src_hit(mem_r, id_s.rs1) || src_hit(mem_r, id_s.rs2)) begin
            hazard_s = 1'b1;
        end else begin
            hazard_s = 1'b0;
        end
    end

    assign fwd_a_s = FWD_RF;
    assign fwd_b_s = FWD_RF;
`endif

    // Freeze beats flush beats hazard; a held EX re-presents its branch later.
    assign freeze_s = ext_stall_i;
    assign flush_s  = branch_taken_ex_i && !freeze_s;
    assign stall_s  = hazard_s && !flush_s && !freeze_s;

    // Next-state logic for the sequencing FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            RUN, HAZ: begin
                if (freeze_s) begin
                    state_nxt_s = HOLD;
                end else if (stall_s) begin
                    state_nxt_s = HAZ;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            HOLD: begin
                if (freeze_s) begin
                    state_nxt_s = HOLD;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            default: begin
                state_nxt_s = RUN;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Shadow pipeline: advances unless frozen, EX gets a bubble on stall/flush.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_r  <= BUBBLE;
            mem_r <= BUBBLE;
            wb_r  <= BUBBLE;
        end else if (!freeze_s) begin
            wb_r  <= mem_r;
            mem_r <= ex_r;
            ex_r  <= (stall_s || flush_s) ? BUBBLE : id_s;
        end else begin
            wb_r  <= wb_r;
            mem_r <= mem_r;
            ex_r  <= ex_r;
        end
    end

    // Saturating count of hazard-stall and freeze cycles.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_r <= 16'd0;
        end else if ((freeze_s || stall_s) && (cnt_r != 16'hFFFF)) begin
            cnt_r <= cnt_r + 16'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign stall_cnt_o = cnt_r;

    // Pipeline enables/flushes; held at reset values while rst_i is high.
    always_comb begin
        pc_en_o      = 1'b1;
        ifid_en_o    = 1'b1;
        ifid_flush_o = 1'b0;
        idex_flush_o = 1'b0;
        fwd_a_o      = FWD_RF;
        fwd_b_o      = FWD_RF;
        if (rst_i) begin
            pc_en_o   = 1'b1;
            ifid_en_o = 1'b1;
        end else if (freeze_s) begin
            pc_en_o   = 1'b0;
            ifid_en_o = 1'b0;
        end else if (flush_s) begin
            ifid_flush_o = 1'b1;
            idex_flush_o = 1'b1;
        end else if (stall_s) begin
            pc_en_o      = 1'b0;
            ifid_en_o    = 1'b0;
            idex_flush_o = 1'b1;
        end else begin
            pc_en_o   = 1'b1;
            ifid_en_o = 1'b1;
        end
        if (!rst_i) begin
            fwd_a_o = fwd_a_s;
            fwd_b_o = fwd_b_s;
        end else begin
            fwd_a_o = FWD_RF;
            fwd_b_o = FWD_RF;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus random traffic
// against an in-flight instruction model. Honours FORWARDING_EN.
`timescale 1ns/1ps
module tb_pipe_ctrl;

`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr_id = 32'd0;
    logic        instr_valid = 1'b0;
    logic        br_taken = 1'b0;
    logic        ext_stall = 1'b0;
    logic        pc_en, ifid_en, ifid_flush, idex_flush;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .instr_id_i        (instr_id),
        .instr_valid_i     (instr_valid),
        .branch_taken_ex_i (br_taken),
        .ext_stall_i       (ext_stall),
        .pc_en_o           (pc_en),
        .ifid_en_o         (ifid_en),
        .ifid_flush_o      (ifid_flush),
        .idex_flush_o      (idex_flush),
        .fwd_a_o           (fwd_a),
        .fwd_b_o           (fwd_b),
        .stall_cnt_o       (stall_cnt)
    );

    // Model of an in-flight instruction: what it writes and what it reads.
    typedef struct packed {
        bit v;
        bit wr;
        int rd;
        bit ld;
        int s1;
        int s2;
    } ment_t;

    ment_t pipe [3];   // 0 = EX, 1 = MEM, 2 = WB
    int    m_cnt;

    function automatic logic [31:0] enc(input logic [4:0] op, input int rd, input int rs1, input int rs2);
        logic [4:0] a, b, c;
        a = rd[4:0];
        b = rs1[4:0];
        c = rs2[4:0];
        return {7'd0, c, b, 3'd0, a, op, 2'b11};
    endfunction

    function automatic logic [31:0] i_lw(input int rd, input int rs1);
        return enc(5'b00000, rd, rs1, 0);
    endfunction

    function automatic logic [31:0] i_add(input int rd, input int rs1, input int rs2);
        return enc(5'b01100, rd, rs1, rs2);
    endfunction

    function automatic logic [31:0] i_addi(input int rd, input int rs1, input int imm);
        return enc(5'b00100, rd, rs1, imm);
    endfunction

    function automatic ment_t mdec(input logic [31:0] ins, input bit v);
        ment_t e;
        int op;
        bit w, u1, u2;
        e = '0;
        op = int'(ins[6:2]);
        if (!v) return e;
        w  = op inside {13, 5, 4, 12, 0, 27, 25};
        u1 = op inside {4, 12, 0, 8, 25, 24};
        u2 = op inside {12, 8, 24};
        e.v  = 1'b1;
        e.rd = int'(ins[11:7]);
        e.wr = w && (e.rd != 0);
        e.ld = (op == 0);
        e.s1 = u1 ? int'(ins[19:15]) : 0;
        e.s2 = u2 ? int'(ins[24:20]) : 0;
        return e;
    endfunction

    function automatic bit m_hit(input ment_t p, input int s);
        return p.v && p.wr && (s != 0) && (p.rd == s);
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 3; i++) pipe[i] = '0;
        m_cnt = 0;
    endfunction

    // Expected outputs for the current inputs and in-flight instructions.
    task automatic model_eval(output bit e_pc, output bit e_ifen, output bit e_iff, output bit e_xf,
                              output bit [1:0] e_a, output bit [1:0] e_b, output bit hz);
        ment_t id;
        id = mdec(instr_id, instr_valid);
        hz = 1'b0;
        for (int st = 0; st < (FWD ? 1 : 2); st++)
            if ((!FWD || pipe[st].ld) && (m_hit(pipe[st], id.s1) || m_hit(pipe[st], id.s2)))
                hz = 1'b1;
        {e_pc, e_ifen, e_iff, e_xf} = 4'b1100;
        if (rst)            {e_pc, e_ifen, e_iff, e_xf} = 4'b1100;
        else if (ext_stall) {e_pc, e_ifen, e_iff, e_xf} = 4'b0000;
        else if (br_taken)  {e_pc, e_ifen, e_iff, e_xf} = 4'b1111;
        else if (hz)        {e_pc, e_ifen, e_iff, e_xf} = 4'b0001;
        e_a = 2'd0;
        e_b = 2'd0;
        if (FWD && !rst) begin
            if (m_hit(pipe[1], pipe[0].s1))      e_a = 2'd1;
            else if (m_hit(pipe[2], pipe[0].s1)) e_a = 2'd2;
            if (m_hit(pipe[1], pipe[0].s2))      e_b = 2'd1;
            else if (m_hit(pipe[2], pipe[0].s2)) e_b = 2'd2;
        end
    endtask

    task automatic set_in(input logic [31:0] ins, input logic v, input logic b, input logic e);
        instr_id = ins;
        instr_valid = v;
        br_taken = b;
        ext_stall = e;
        if (rst) model_clear();
        #1;
    endtask

    // One clock: advance the model with this cycle's inputs, end at negedge.
    task automatic tick();
        bit a, b, c, d, hz;
        bit [1:0] x, y;
        ment_t id;
        model_eval(a, b, c, d, x, y, hz);
        id = mdec(instr_id, instr_valid);
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            if (!ext_stall) begin
                pipe[2] = pipe[1];
                pipe[1] = pipe[0];
                pipe[0] = (hz || br_taken) ? ment_t'('0) : id;
            end
            if ((ext_stall || (hz && !br_taken)) && m_cnt < 65535) m_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(32'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(i_add(6, 5, 5), 1'b1, 1'b1, 1'b1);
        total++;
        if ({pc_en, ifid_en, ifid_flush, idex_flush} !== 4'b1100) begin
            bad++;
            $display("FAIL reset_ctl got=%b want=1100", {pc_en, ifid_en, ifid_flush, idex_flush});
        end
        total++;
        if ({fwd_a, fwd_b} !== 4'b0000 || stall_cnt !== 16'd0) begin
            bad++;
            $display("FAIL reset_fwd_cnt got fwd=%b cnt=%0d want fwd=0000 cnt=0", {fwd_a, fwd_b}, stall_cnt);
        end
        do_reset();
    endtask

    task automatic test_load_use();
        do_reset();
        set_in(i_lw(5, 1), 1'b1, 1'b0, 1'b0);
        total++;
        if (pc_en !== 1'b1 || idex_flush !== 1'b0) begin
            bad++;
            $display("FAIL lu_issue got pc_en=%b idex_flush=%b want 1 0", pc_en, idex_flush);
        end
        tick();
        set_in(i_add(6, 5, 2), 1'b1, 1'b0, 1'b0);
        total++;
        if (pc_en !== 1'b0 || ifid_en !== 1'b0 || idex_flush !== 1'b1) begin
            bad++;
            $display("FAIL lu_stall got pc=%b ifid=%b xf=%b want 0 0 1", pc_en, ifid_en, idex_flush);
        end
        tick();
        total++;
        if (pc_en !== (FWD ? 1'b1 : 1'b0)) begin
            bad++;
            $display("FAIL lu_second got pc_en=%b want %b", pc_en, FWD ? 1'b1 : 1'b0);
        end
        tick();
        set_in(FWD ? 32'd0 : i_add(6, 5, 2), FWD ? 1'b0 : 1'b1, 1'b0, 1'b0);
        total++;
        if (pc_en !== 1'b1 || fwd_a !== (FWD ? 2'b10 : 2'b00) || stall_cnt !== (FWD ? 16'd1 : 16'd2)) begin
            bad++;
            $display("FAIL lu_after got pc=%b fwd_a=%b cnt=%0d want 1 %b %0d",
                     pc_en, fwd_a, stall_cnt, FWD ? 2'b10 : 2'b00, FWD ? 1 : 2);
        end
        tick();
        set_in(32'd0, 1'b0, 1'b0, 1'b0);
        total++;
        if (fwd_a !== 2'b00 || stall_cnt !== (FWD ? 16'd1 : 16'd2)) begin
            bad++;
            $display("FAIL lu_drain got fwd_a=%b cnt=%0d want 00 %0d", fwd_a, stall_cnt, FWD ? 1 : 2);
        end
    endtask

    task automatic test_fwd_pair();
        do_reset();
        set_in(i_addi(5, 0, 1), 1'b1, 1'b0, 1'b0);
        tick();
        set_in(i_add(6, 5, 5), 1'b1, 1'b0, 1'b0);
        total++;
        if (pc_en !== (FWD ? 1'b1 : 1'b0)) begin
            bad++;
            $display("FAIL fp_id got pc_en=%b want %b", pc_en, FWD ? 1'b1 : 1'b0);
        end
        tick();
        set_in(FWD ? 32'd0 : i_add(6, 5, 5), FWD ? 1'b0 : 1'b1, 1'b0, 1'b0);
        total++;
        if (pc_en !== (FWD ? 1'b1 : 1'b0) || fwd_a !== (FWD ? 2'b01 : 2'b00) || fwd_b !== (FWD ? 2'b01 : 2'b00)) begin
            bad++;
            $display("FAIL fp_ex got pc=%b a=%b b=%b want %b %b %b", pc_en, fwd_a, fwd_b,
                     FWD ? 1'b1 : 1'b0, FWD ? 2'b01 : 2'b00, FWD ? 2'b01 : 2'b00);
        end
        tick();
        set_in(FWD ? 32'd0 : i_add(6, 5, 5), FWD ? 1'b0 : 1'b1, 1'b0, 1'b0);
        total++;
        if (pc_en !== 1'b1 || stall_cnt !== (FWD ? 16'd0 : 16'd2)) begin
            bad++;
            $display("FAIL fp_cnt got pc=%b cnt=%0d want 1 %0d", pc_en, stall_cnt, FWD ? 0 : 2);
        end
        tick();
    endtask

    task automatic test_branch_flush();
        do_reset();
        set_in(i_lw(5, 1), 1'b1, 1'b0, 1'b0);
        tick();
        set_in(i_add(6, 5, 2), 1'b1, 1'b1, 1'b0);
        total++;
        if ({pc_en, ifid_en, ifid_flush, idex_flush} !== 4'b1111) begin
            bad++;
            $display("FAIL br_flush got=%b want=1111", {pc_en, ifid_en, ifid_flush, idex_flush});
        end
        tick();
        set_in(32'd0, 1'b0, 1'b0, 1'b0);
        total++;
        if (stall_cnt !== 16'd0) begin
            bad++;
            $display("FAIL br_cnt got=%0d want=0", stall_cnt);
        end
    endtask

    task automatic test_x0();
        do_reset();
        set_in(i_addi(0, 0, 5), 1'b1, 1'b0, 1'b0);
        tick();
        set_in(i_add(1, 0, 0), 1'b1, 1'b0, 1'b0);
        total++;
        if (pc_en !== 1'b1 || idex_flush !== 1'b0) begin
            bad++;
            $display("FAIL x0_stall got pc=%b xf=%b want 1 0", pc_en, idex_flush);
        end
        tick();
        set_in(32'd0, 1'b0, 1'b0, 1'b0);
        total++;
        if (fwd_a !== 2'b00 || fwd_b !== 2'b00 || stall_cnt !== 16'd0) begin
            bad++;
            $display("FAIL x0_fwd got a=%b b=%b cnt=%0d want 00 00 0", fwd_a, fwd_b, stall_cnt);
        end
    endtask

    task automatic test_freeze_reset();
        int hzc;
        hzc = FWD ? 1 : 2;
        do_reset();
        set_in(i_lw(5, 1), 1'b1, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            set_in(i_add(6, 5, 5), 1'b1, (i == 1), 1'b1);
            total++;
            if ({pc_en, ifid_en, ifid_flush, idex_flush} !== 4'b0000) begin
                bad++;
                $display("FAIL frz_hold%0d got=%b want=0000", i, {pc_en, ifid_en, ifid_flush, idex_flush});
            end
            tick();
        end
        for (int h = 0; h < hzc; h++) begin
            set_in(i_add(6, 5, 5), 1'b1, 1'b0, 1'b0);
            total++;
            if (pc_en !== 1'b0 || idex_flush !== 1'b1) begin
                bad++;
                $display("FAIL frz_haz%0d got pc=%b xf=%b want 0 1", h, pc_en, idex_flush);
            end
            tick();
        end
        set_in(i_add(6, 5, 5), 1'b1, 1'b0, 1'b0);
        total++;
        if (pc_en !== 1'b1 || stall_cnt !== 16'(3 + hzc)) begin
            bad++;
            $display("FAIL frz_cnt got pc=%b cnt=%0d want 1 %0d", pc_en, stall_cnt, 3 + hzc);
        end
        tick();
        set_in(i_lw(7, 1), 1'b1, 1'b0, 1'b0);
        tick();
        set_in(i_add(8, 7, 7), 1'b1, 1'b0, 1'b1);
        tick();
        rst = 1'b1;
        #1;
        total++;
        if ({pc_en, ifid_en, ifid_flush, idex_flush, fwd_a, fwd_b} !== 8'b1100_0000 || stall_cnt !== 16'd0) begin
            bad++;
            $display("FAIL frz_rst got=%b cnt=%0d want=11000000 cnt=0",
                     {pc_en, ifid_en, ifid_flush, idex_flush, fwd_a, fwd_b}, stall_cnt);
        end
        tick();
        rst = 1'b0;
        set_in(i_add(8, 7, 7), 1'b1, 1'b0, 1'b0);
        total++;
        if (pc_en !== 1'b1 || idex_flush !== 1'b0 || stall_cnt !== 16'd0) begin
            bad++;
            $display("FAIL frz_post got pc=%b xf=%b cnt=%0d want 1 0 0", pc_en, idex_flush, stall_cnt);
        end
        tick();
    endtask

    task automatic test_random();
        int ops [10] = '{0, 4, 5, 8, 12, 13, 24, 25, 27, 3};
        logic [31:0] ins;
        bit a, b, c, d, hz;
        bit [1:0] x, y;
        do_reset();
        model_clear();
        for (int n = 0; n < 800; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            ins = enc(5'(ops[$urandom_range(0, 9)]), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            ins[31:25] = 7'($urandom);
            ins[14:12] = 3'($urandom);
            set_in(ins, ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
            model_eval(a, b, c, d, x, y, hz);
            total++;
            if ({pc_en, ifid_en, ifid_flush, idex_flush} !== {a, b, c, d} || fwd_a !== x || fwd_b !== y ||
                stall_cnt !== 16'(m_cnt)) begin
                bad++;
                $display("FAIL rand cyc=%0d got ctl=%b a=%b b=%b cnt=%0d want ctl=%b a=%b b=%b cnt=%0d",
                         n, {pc_en, ifid_en, ifid_flush, idex_flush}, fwd_a, fwd_b, stall_cnt,
                         {a, b, c, d}, x, y, m_cnt);
            end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        model_clear();
        @(negedge clk);
        test_reset();
        test_load_use();
        test_fwd_pair();
        test_branch_flush();
        test_x0();
        test_freeze_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
